// File: rtl/frac_divider.sv
// Restoring radix-2 unsigned divider: one quotient bit per cycle, fixed W+1 cycle
// latency from start to complete, with quotient and remainder held until the next result.
module frac_divider #(
  parameter int W    = 47,
  parameter int LG_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] srcA,
  input  logic [W-1:0] srcB,
  input  logic         start_div,
  output logic         ready,
  output logic         complete,
  output logic [W-1:0] y,
  output logic [W-1:0] rem
);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    dvd_q;       // dividend shifts out MSB-first, quotient bits shift in at LSB
  logic [W-1:0]    dvs_q;
  logic [W:0]      prem_q;
  logic [LG_W-1:0] cnt_q;

  logic [W:0]      prem_shift;
  logic [W:0]      prem_nxt;
  logic            q_bit;

  // One restoring step; a zero divisor always subtracts, giving an all-ones quotient.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    prem_shift = (prem_q << 1) | {{W{1'b0}}, dvd_q[W-1]};
    prem_nxt   = prem_shift;
    q_bit      = 1'b0;
    if (prem_shift >= {1'b0, dvs_q}) begin
      prem_nxt = prem_shift - {1'b0, dvs_q};
      q_bit    = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_div) state_nxt = DIVIDE;
      DIVIDE:  if (cnt_q == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready    = (state == IDLE);
  assign complete = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      dvd_q  <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      cnt_q  <= '0;
      y      <= '0;
      rem    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start_div) begin
            dvd_q  <= srcA;
            dvs_q  <= srcB;
            prem_q <= '0;
            cnt_q  <= LG_W'(W - 1);
          end
        end
        DIVIDE: begin
          dvd_q  <= {dvd_q[W-2:0], q_bit};
          prem_q <= prem_nxt;
          cnt_q  <= cnt_q - 1'b1;
          // The final step's results are captured directly so y/rem are valid in DONE.
          if (cnt_q == '0) begin
            y   <= {dvd_q[W-2:0], q_bit};
            rem <= prem_nxt[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frac_divider.sv
// Self-checking bench for frac_divider: directed table, back-to-back and held-start
// sequences, reset abort, and randomized operands against a floor-division model.
module tb_frac_divider;

  localparam int W    = 47;
  localparam int LG_W = 6;
  localparam int LAT  = W + 1;

  logic         clk;
  logic         reset;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic         start_div;
  logic         ready;
  logic         complete;
  logic [W-1:0] y;
  logic [W-1:0] rem;

  frac_divider #(.W(W), .LG_W(LG_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .srcA     (srcA),
    .srcB     (srcB),
    .start_div(start_div),
    .ready    (ready),
    .complete (complete),
    .y        (y),
    .rem      (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // complete must never be high on two consecutive cycles
  logic prev_c = 1'b0;
  always @(posedge clk) begin
    assert (!(complete && prev_c)) else $error("FAIL double_complete at %0t", $time);
    prev_c <= complete;
  end

  logic prev_neg = 1'b0;
  always @(negedge clk) begin
    if (complete) check("single_complete", 64'(prev_neg), 64'(0));
    prev_neg <= complete;
  end

  // Starts a divide when ready, waits for complete, checks latency, busy-ready and results.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ey, input logic [W-1:0] er, input string tag);
    int lat;
    int wait_n;
    bit ready_seen;
    wait_n = 0;
    @(negedge clk);
    while (!ready && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    check({tag, "_ready_idle"}, 64'(ready), 64'(1));
    srcA      = a;
    srcB      = b;
    start_div = 1'b1;
    @(negedge clk);
    start_div  = 1'b0;
    lat        = 1;
    ready_seen = 1'b0;
    while (!complete && lat < 4 * W) begin
      ready_seen |= ready;
      @(negedge clk);
      lat++;
    end
    ready_seen |= ready;
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_ready_busy"}, 64'(ready_seen), 64'(0));
    check({tag, "_y"}, 64'(y), 64'(ey));
    check({tag, "_rem"}, 64'(rem), 64'(er));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ey;
    logic [W-1:0] er;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } res_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] a, b, eq, er;
    res_t         exp_q[$];
    res_t         got;
    int           last;
    int           guard;
    bit           saw;

    vecs[0] = '{47'h4000_0000_0000, 47'h80_0000,         47'h80_0000,         47'h0};
    vecs[1] = '{47'h6000_0000_0000, 47'h80_0000,         47'hC0_0000,         47'h0};
    vecs[2] = '{47'd100,            47'd7,               47'd14,              47'd2};
    vecs[3] = '{47'h1234,           47'h0,               47'h7FFF_FFFF_FFFF,  47'h1234};
    vecs[4] = '{47'd5,              47'd9,               47'd0,               47'd5};
    vecs[5] = '{47'h1_2345_6789,    47'h1_2345_6789,     47'd1,               47'd0};
    vecs[6] = '{47'h7FFF_FFFF_FFFF, 47'd1,               47'h7FFF_FFFF_FFFF,  47'd0};
    vecs[7] = '{47'h7FFF_FFFF_FFFF, 47'h7FFF_FFFF_FFFF,  47'd1,               47'd0};
    vecs[8] = '{47'd0,              47'd5,               47'd0,               47'd0};
    vecs[9] = '{47'h7FFF_FFFF_FFFF, 47'd2,               47'h3FFF_FFFF_FFFF,  47'd1};

    // Reset with start_div asserted: the start must be ignored.
    reset     = 1'b1;
    start_div = 1'b1;
    srcA      = 47'd77;
    srcB      = 47'd3;
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    start_div = 1'b0;
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_complete", 64'(complete), 64'(0));
    check("rst_y", 64'(y), 64'(0));
    check("rst_rem", 64'(rem), 64'(0));
    @(negedge clk);
    check("rst_start_ignored", 64'(ready), 64'(1));

    // Directed table; entries 1 and 2 run back-to-back from the IDLE cycle after DONE.
    for (int i = 0; i < 10; i++)
      run_div(vecs[i].a, vecs[i].b, vecs[i].ey, vecs[i].er, $sformatf("vec%0d", i));

    // start_div held high with operands changing every cycle.
    last      = -1;
    start_div = 1'b1;
    for (int c = 0; c < 3 * (W + 2) + 2; c++) begin
      @(negedge clk);
      if (complete) begin
        if (exp_q.size() > 0) begin
          got = exp_q.pop_front();
          check("held_y", 64'(y), 64'(got.q));
          check("held_rem", 64'(rem), 64'(got.r));
        end else begin
          check("held_unexpected_complete", 64'(1), 64'(0));
        end
        if (last >= 0) check("held_spacing", 64'(c - last), 64'(W + 2));
        last = c;
      end
      srcA = rnd();
      srcB = rnd() >> $urandom_range(0, 40);
      if (ready) begin
        ref_div(srcA, srcB, eq, er);
        exp_q.push_back('{eq, er});
      end
    end
    start_div = 1'b0;
    guard     = 0;
    while (exp_q.size() > 0 && guard < 3 * W) begin
      @(negedge clk);
      if (complete) begin
        got = exp_q.pop_front();
        check("held_drain_y", 64'(y), 64'(got.q));
        check("held_drain_rem", 64'(rem), 64'(got.r));
      end
      guard++;
    end
    check("held_drained", 64'(exp_q.size()), 64'(0));

    // Reset 10 cycles into a divide aborts it with no complete pulse.
    run_div(47'd1000, 47'd3, 47'd333, 47'd1, "pre_abort");
    @(negedge clk);
    srcA      = 47'h1234_5678;
    srcB      = 47'd11;
    start_div = 1'b1;
    @(negedge clk);
    start_div = 1'b0;
    repeat (9) @(negedge clk);
    reset     = 1'b1;
    start_div = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    start_div = 1'b0;
    check("abort_ready", 64'(ready), 64'(1));
    check("abort_y", 64'(y), 64'(0));
    check("abort_rem", 64'(rem), 64'(0));
    saw = 1'b0;
    for (int c = 0; c < W + 5; c++) begin
      saw |= complete;
      @(negedge clk);
    end
    check("abort_no_complete", 64'(saw), 64'(0));
    run_div(47'd9, 47'd3, 47'd3, 47'd0, "post_abort");

    // Randomized operands, biased toward the edge classes.
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 5))
        0: begin a = rnd(); b = rnd(); end
        1: begin a = rnd(); b = rnd() >> $urandom_range(0, 46); end
        2: begin b = rnd() >> $urandom_range(0, 46); a = b; end
        3: begin
          b = rnd() >> $urandom_range(0, 30);
          if (b == '0) b = 47'd1;
          a = rnd() % b;
        end
        4: begin a = rnd() >> $urandom_range(0, 46); b = '0; end
        default: begin a = W'($urandom_range(0, 1000)); b = W'($urandom_range(1, 50)); end
      endcase
      ref_div(a, b, eq, er);
      run_div(a, b, eq, er, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
